// File: rtl/spartan_upsize.sv
// -----------------------------------------------------------------------------
// spartan_upsize
//
// Far end of a narrow Spartan channel. It rebuilds the full-width link from the
// half-width link that the downsizer produces. The two directions are
// independent buffered state machines.
//
//   Master path (half -> full): two half beats are assembled into one full word.
//   Slave path  (full -> half): one full word is split into two half beats.
//
// Beat order on the half link is the same as in the downsizer:
//   beat 0 = full[HW-1:0], beat 1 = full[2*HW-1:HW]
//
// State table
//   phaseM  | meaning
//   --------+----------------------------------------------------------
//   mExpLo  | next accepted half master beat is the low half (beat 0)
//   mExpHi  | low half is in loReg; next beat completes the full word
//
//   phaseS  | meaning (valid only while hold=1)
//   --------+----------------------------------------------------------
//   sBeat0  | presenting bufReg low half on the half slave link
//   sBeat1  | presenting bufReg high half; its accept frees the buffer
//
// Ports
//   CLK          clock; all logic changes on the rising edge
//   RST          synchronous active-high reset, registered once (rstIn)
//   SpMBUS_HALF  half master beat in           (HW bits)
//   SpMVLD_HALF  half master valid in
//   SpMRDY_HALF  half master ready out
//   SpSBUS_HALF  half slave beat out           (HW bits)
//   SpSVLD_HALF  half slave valid out
//   SpSRDY_HALF  half slave ready in
//   SpMBUS_FULL  full master word out          (BWIDTH+2 bits)
//   SpMVLD_FULL  full master valid out
//   SpMRDY_FULL  full master ready in
//   SpSBUS_FULL  full slave word in            (BWIDTH+2 bits)
//   SpSVLD_FULL  full slave valid in
//   SpSRDY_FULL  full slave ready out
//
// BWIDTH must be even so that the full bus (BWIDTH+2) splits into two equal
// halves of BWIDTH/2+1 bits.
// -----------------------------------------------------------------------------
module spartan_upsize #(
  parameter int BWIDTH = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BWIDTH/2:0]   SpMBUS_HALF,
  input  logic                SpMVLD_HALF,
  output logic                SpMRDY_HALF,
  output logic [BWIDTH/2:0]   SpSBUS_HALF,
  output logic                SpSVLD_HALF,
  input  logic                SpSRDY_HALF,
  output logic [BWIDTH+1:0]   SpMBUS_FULL,
  output logic                SpMVLD_FULL,
  input  logic                SpMRDY_FULL,
  input  logic [BWIDTH+1:0]   SpSBUS_FULL,
  input  logic                SpSVLD_FULL,
  output logic                SpSRDY_FULL
);

  localparam int HW = BWIDTH/2 + 1;
  localparam int FW = BWIDTH + 2;

  localparam logic [0:0] mExpLo = 1'b0;
  localparam logic [0:0] mExpHi = 1'b1;
  localparam logic [0:0] sBeat0 = 1'b0;
  localparam logic [0:0] sBeat1 = 1'b1;

  // Registered copy of RST; every control register clears while it is high.
  logic rstIn;

  always_ff @(posedge CLK) begin
    rstIn <= RST;
  end

  // ---------------------------------------------------------------------------
  // Master expand path
  // ---------------------------------------------------------------------------
  logic [0:0]    phaseM;
  logic [HW-1:0] loReg;
  logic          outVld;
  logic [FW-1:0] outReg;

  logic mHalfAcc;
  logic mFullAcc;
  logic mLoAcc;
  logic mHiAcc;

  // The low beat only fills loReg, so it can always be taken. The high beat
  // overwrites outReg and therefore needs the output slot to be free or
  // draining in this same cycle.
  assign SpMRDY_HALF = (phaseM == mExpLo) || !outVld || SpMRDY_FULL;

  assign mHalfAcc = SpMVLD_HALF && SpMRDY_HALF;
  assign mFullAcc = outVld && SpMRDY_FULL;
  assign mLoAcc   = mHalfAcc && (phaseM == mExpLo);
  assign mHiAcc   = mHalfAcc && (phaseM == mExpHi);

  always_ff @(posedge CLK) begin
    if (rstIn) begin
      phaseM <= mExpLo;
      outVld <= 1'b0;
    end else begin
      if (mLoAcc) begin
        phaseM <= mExpHi;
      end else if (mHiAcc) begin
        phaseM <= mExpLo;
      end

      // A completing high beat wins over a drain, so a word leaving and a new
      // word arriving on the same edge keep the output valid without a bubble.
      if (mHiAcc) begin
        outVld <= 1'b1;
      end else if (mFullAcc) begin
        outVld <= 1'b0;
      end
    end
  end

  // Data registers carry no reset; they are qualified by phaseM / outVld.
  always_ff @(posedge CLK) begin
    if (mLoAcc) begin
      loReg <= SpMBUS_HALF;
    end
    if (mHiAcc) begin
      outReg <= {SpMBUS_HALF, loReg};
    end
  end

  assign SpMVLD_FULL = outVld;
  assign SpMBUS_FULL = outReg;

  // ---------------------------------------------------------------------------
  // Slave reduce path
  // ---------------------------------------------------------------------------
  logic          hold;
  logic [0:0]    phaseS;
  logic [FW-1:0] bufReg;

  logic sFullAcc;
  logic sHalfAcc;

  // A new full word may enter when the buffer is empty, or when the last
  // half of the buffered word is leaving this cycle (gapless streaming).
  assign SpSRDY_FULL = !hold || ((phaseS == sBeat1) && SpSRDY_HALF);

  assign sFullAcc = SpSVLD_FULL && SpSRDY_FULL;
  assign sHalfAcc = hold && SpSRDY_HALF;

  always_ff @(posedge CLK) begin
    if (rstIn) begin
      hold   <= 1'b0;
      phaseS <= sBeat0;
    end else begin
      if (sFullAcc) begin
        hold   <= 1'b1;
        phaseS <= sBeat0;
      end else if (sHalfAcc) begin
        if (phaseS == sBeat0) begin
          phaseS <= sBeat1;
        end else begin
          hold   <= 1'b0;
          phaseS <= sBeat0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (sFullAcc) begin
      bufReg <= SpSBUS_FULL;
    end
  end

  assign SpSVLD_HALF = hold;
  assign SpSBUS_HALF = (phaseS == sBeat1) ? bufReg[FW-1:HW] : bufReg[HW-1:0];

endmodule

// File: tb/tb_spartan_upsize.sv
module tb_spartan_upsize;

  localparam int BW = 64;
  localparam int HW = BW/2 + 1;
  localparam int FW = BW + 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [HW-1:0] SpMBUS_HALF;
  logic          SpMVLD_HALF;
  logic          SpMRDY_HALF;
  logic [HW-1:0] SpSBUS_HALF;
  logic          SpSVLD_HALF;
  logic          SpSRDY_HALF;
  logic [FW-1:0] SpMBUS_FULL;
  logic          SpMVLD_FULL;
  logic          SpMRDY_FULL;
  logic [FW-1:0] SpSBUS_FULL;
  logic          SpSVLD_FULL;
  logic          SpSRDY_FULL;

  spartan_upsize #(.BWIDTH(BW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SpMBUS_HALF (SpMBUS_HALF),
    .SpMVLD_HALF (SpMVLD_HALF),
    .SpMRDY_HALF (SpMRDY_HALF),
    .SpSBUS_HALF (SpSBUS_HALF),
    .SpSVLD_HALF (SpSVLD_HALF),
    .SpSRDY_HALF (SpSRDY_HALF),
    .SpMBUS_FULL (SpMBUS_FULL),
    .SpMVLD_FULL (SpMVLD_FULL),
    .SpMRDY_FULL (SpMRDY_FULL),
    .SpSBUS_FULL (SpSBUS_FULL),
    .SpSVLD_FULL (SpSVLD_FULL),
    .SpSRDY_FULL (SpSRDY_FULL)
  );

  always #5 CLK = ~CLK;

  int nCmp = 0;
  int nBad = 0;

  // Scoreboard queues: expected full master words and expected half slave beats.
  logic [FW-1:0] qFull[$];
  logic [HW-1:0] qHalf[$];
  logic [HW-1:0] pendLo;
  bit            haveLo = 1'b0;

  // Bench copy of the registered reset, and one edge later (state cleared).
  bit rstSeen  = 1'b0;
  bit rstSeenD = 1'b0;
  bit stopSinks = 1'b0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic failNow(input string nm);
    nCmp++;
    nBad++;
    $display("FAIL %s: got timeout/unexpected event, required none", nm);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [HW-1:0] rndHalf();
    logic [HW-1:0] v;
    v = {1'($urandom_range(0, 1)), 32'($urandom)};
    return v;
  endfunction

  function automatic logic [FW-1:0] rndFull();
    logic [FW-1:0] v;
    v = {2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)};
    return v;
  endfunction

  // Called at posedge+1. Ready is examined at +2 so that any sink process
  // driving the far-side ready at +1 has already settled.
  task automatic sendHalf(input logic [HW-1:0] b);
    int n;
    n = 0;
    SpMBUS_HALF = b;
    SpMVLD_HALF = 1'b1;
    #1;
    while (!SpMRDY_HALF && n < 300) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (n >= 300) failNow("mhalf_accept_timeout");
    @(posedge CLK);
    #1;
    SpMVLD_HALF = 1'b0;
  endtask

  task automatic sendFull(input logic [FW-1:0] w);
    int n;
    n = 0;
    SpSBUS_FULL = w;
    SpSVLD_FULL = 1'b1;
    #1;
    while (!SpSRDY_FULL && n < 300) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (n >= 300) failNow("sfull_accept_timeout");
    @(posedge CLK);
    #1;
    SpSVLD_FULL = 1'b0;
  endtask

  task automatic randomizeInputs();
    SpMBUS_HALF = rndHalf();
    SpMVLD_HALF = 1'($urandom_range(0, 1));
    SpMRDY_FULL = 1'($urandom_range(0, 1));
    SpSBUS_FULL = rndFull();
    SpSVLD_FULL = 1'($urandom_range(0, 1));
    SpSRDY_HALF = 1'($urandom_range(0, 1));
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      rstSeenD = rstSeen;
      rstSeen  = RST;
    end
  end

  // Monitor: samples at the falling edge, where values equal those the DUT
  // sees at the next rising edge. Handshakes seen here happen at that edge.
  initial begin : monitor
    bit            prevMv, prevMacc, prevSv, prevSacc;
    logic [FW-1:0] prevMbus;
    logic [HW-1:0] prevSbus;
    logic [FW-1:0] e;
    logic [HW-1:0] eh;
    prevMv = 0; prevMacc = 0; prevSv = 0; prevSacc = 0;
    prevMbus = '0; prevSbus = '0;
    forever begin
      @(negedge CLK);
      if (rstSeenD) begin
        chk("rst_mvld_full", SpMVLD_FULL, 0);
        chk("rst_svld_half", SpSVLD_HALF, 0);
        chk("rst_mrdy_half", SpMRDY_HALF, 1);
        chk("rst_srdy_full", SpSRDY_FULL, 1);
      end
      if (rstSeen) begin
        qFull.delete();
        qHalf.delete();
        haveLo = 1'b0;
        prevMv = 0;
        prevSv = 0;
      end else begin
        if (prevMv && !prevMacc) begin
          chk("mfull_hold_vld", SpMVLD_FULL, 1);
          chk("mfull_hold_bus", SpMBUS_FULL, prevMbus);
        end
        if (prevSv && !prevSacc) begin
          chk("shalf_hold_vld", SpSVLD_HALF, 1);
          chk("shalf_hold_bus", SpSBUS_HALF, prevSbus);
        end

        if (SpMVLD_FULL && SpMRDY_FULL) begin
          if (qFull.size() == 0) failNow("mfull_unexpected");
          else begin
            e = qFull.pop_front();
            chk("mfull_data", SpMBUS_FULL, e);
          end
        end
        if (SpSVLD_HALF && SpSRDY_HALF) begin
          if (qHalf.size() == 0) failNow("shalf_unexpected");
          else begin
            eh = qHalf.pop_front();
            chk("shalf_data", SpSBUS_HALF, eh);
          end
        end

        // Reference model: pair half beats low-then-high; split full words low-then-high.
        if (SpMVLD_HALF && SpMRDY_HALF) begin
          if (haveLo) begin
            qFull.push_back({SpMBUS_HALF, pendLo});
            haveLo = 1'b0;
          end else begin
            pendLo = SpMBUS_HALF;
            haveLo = 1'b1;
          end
        end
        if (SpSVLD_FULL && SpSRDY_FULL) begin
          qHalf.push_back(SpSBUS_FULL[HW-1:0]);
          qHalf.push_back(SpSBUS_FULL[FW-1:HW]);
        end

        prevMv   = SpMVLD_FULL;
        prevMacc = SpMVLD_FULL && SpMRDY_FULL;
        prevMbus = SpMBUS_FULL;
        prevSv   = SpSVLD_HALF;
        prevSacc = SpSVLD_HALF && SpSRDY_HALF;
        prevSbus = SpSBUS_HALF;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [HW-1:0] lo, hi, b0, b1, b2, b3;
    logic [FW-1:0] w;

    // Reset with random inputs.
    RST = 1'b1;
    randomizeInputs();
    tick();
    randomizeInputs();
    tick();
    RST = 1'b0;
    SpMVLD_HALF = 0; SpSVLD_FULL = 0; SpMRDY_FULL = 1; SpSRDY_HALF = 1;
    tick();
    tick();
    chk("post_rst_mrdy_half", SpMRDY_HALF, 1);
    chk("post_rst_srdy_full", SpSRDY_FULL, 1);

    // Expand basic.
    lo = 33'h0_11223344;
    hi = 33'h1_55667788;
    sendHalf(lo);
    sendHalf(hi);
    chk("exp_lat_vld", SpMVLD_FULL, 1);
    chk("exp_lat_bus", SpMBUS_FULL, {hi, lo});
    tick();
    chk("exp_one_cycle", SpMVLD_FULL, 0);

    // Expand backpressure.
    SpMRDY_FULL = 0;
    b0 = rndHalf(); b1 = rndHalf(); b2 = rndHalf(); b3 = rndHalf();
    sendHalf(b0);
    sendHalf(b1);
    sendHalf(b2);
    SpMBUS_HALF = b3;
    SpMVLD_HALF = 1;
    #1;
    chk("bp_rdy_low_4th", SpMRDY_HALF, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_word_a_held", SpMBUS_FULL, {b1, b0});
    end
    SpMRDY_FULL = 1;
    tick();
    SpMVLD_HALF = 0;
    chk("bp_word_b_vld", SpMVLD_FULL, 1);
    chk("bp_word_b_bus", SpMBUS_FULL, {b3, b2});
    tick();
    chk("bp_drained", SpMVLD_FULL, 0);

    // Reduce basic.
    SpSRDY_HALF = 1;
    w = 66'h2_AAAA_BBBB_CCCC_DDDD;
    sendFull(w);
    chk("red_b0_vld", SpSVLD_HALF, 1);
    chk("red_b0_bus", SpSBUS_HALF, w[HW-1:0]);
    tick();
    chk("red_b1_vld", SpSVLD_HALF, 1);
    chk("red_b1_bus", SpSBUS_HALF, w[FW-1:HW]);
    chk("red_b1_srdy", SpSRDY_FULL, 1);
    tick();
    chk("red_done", SpSVLD_HALF, 0);

    // Randomized streaming on both paths at once with random stalls.
    stopSinks = 0;
    fork
      begin
        while (!stopSinks) begin
          tick();
          SpMRDY_FULL = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        while (!stopSinks) begin
          tick();
          SpSRDY_HALF = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          sendHalf(rndHalf());
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 1)) tick();
          sendFull(rndFull());
        end
      end
    join
    for (int i = 0; i < 400 && (qFull.size() > 0 || qHalf.size() > 0); i++) tick();
    chk("drain_full", FW'(qFull.size()), 0);
    chk("drain_half", FW'(qHalf.size()), 0);
    stopSinks = 1;
    tick();
    tick();

    // Reset mid-operation: expand holds a low beat, reduce sits in phase 1.
    SpMRDY_FULL = 1;
    SpSRDY_HALF = 0;
    sendHalf(rndHalf());
    sendFull(rndFull());
    SpSRDY_HALF = 1;
    tick();
    SpSRDY_HALF = 0;
    tick();
    RST = 1;
    randomizeInputs();
    tick();
    randomizeInputs();
    tick();
    RST = 0;
    SpMVLD_HALF = 0; SpSVLD_FULL = 0; SpMRDY_FULL = 1; SpSRDY_HALF = 1;
    tick();
    tick();
    chk("rst_mid_no_stale_s", SpSVLD_HALF, 0);
    chk("rst_mid_no_stale_m", SpMVLD_FULL, 0);
    lo = rndHalf();
    hi = rndHalf();
    sendHalf(lo);
    sendHalf(hi);
    chk("rst_mid_first_vld", SpMVLD_FULL, 1);
    chk("rst_mid_first_bus", SpMBUS_FULL, {hi, lo});
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/spartan_upsize.md
Name: spartan_upsize

Overview:
Restores a half-width Spartan link to full width at the far end of a narrow channel produced by the downsizer.
- Master path: pairs of half-width master beats are assembled into one full-width master word.
- Slave path: full-width slave words are split into pairs of half-width beats.
- Both paths are self-contained buffered state machines; no submodules.
- Sits between the narrow link and a full-width Spartan slave/interconnect port.

Parameters:
BWIDTH, 64, full data width; full bus = BWIDTH+2 bits, half bus HW = BWIDTH/2+1 bits; BWIDTH must be even.

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  reset, synchronous, active-high; registered once internally (rst_in)
SpMBUS_HALF  input  HW  half-width master beat in
SpMVLD_HALF  input  1  half master valid
SpMRDY_HALF  output  1  half master ready
SpSBUS_HALF  output  HW  half-width slave beat out
SpSVLD_HALF  output  1  half slave valid
SpSRDY_HALF  input  1  half slave ready
SpMBUS_FULL  output  BWIDTH+2  full master word out
SpMVLD_FULL  output  1  full master valid
SpMRDY_FULL  input  1  full master ready
SpSBUS_FULL  input  BWIDTH+2  full slave word in
SpSVLD_FULL  input  1  full slave valid
SpSRDY_FULL  output  1  full slave ready

Behaviour:
- Transfer occurs on a cycle where VLD && RDY are both high. Data and VLD are held stable until accepted.
- Beat order on the half link: beat 0 = full[HW-1:0], beat 1 = full[2*HW-1:HW]. This matches the downsizer's split.
- Reset: RST is sampled into rst_in. While rst_in=1, all state clears at the clock edge:
  - SpMVLD_FULL=0, SpSVLD_HALF=0, both phase bits=0.
  - Data registers are don't-care.
  - RST asserted mid-word discards any partial or held word. There is no flush.
- Master expand path. State: phase_m (0=expect low, 1=expect high), lo_reg[HW], out_vld, out_reg.
  - SpMRDY_HALF = (phase_m==0) || (!out_vld || SpMRDY_FULL).
  - phase 0 accept: lo_reg<=beat; phase_m<=1. The low beat is accepted even while out_vld is held.
  - phase 1 accept: out_reg<={beat, lo_reg}; out_vld<=1; phase_m<=0.
  - SpMVLD_FULL=out_vld, SpMBUS_FULL=out_reg. out_vld clears when the full word is accepted and no new high beat completes in the same cycle.
  - Simultaneous full accept and high-beat accept: out_reg is reloaded and out_vld stays 1. No bubble.
  - Latency: full word is valid the cycle after the high beat is accepted. Sustained throughput is 1 full word per 2 cycles.
- Slave reduce path. State: hold (full word buffered), phase_s, buf_reg[BWIDTH+2].
  - SpSRDY_FULL = !hold || (phase_s==1 && SpSRDY_HALF).
  - Full accept: buf_reg<=word; hold<=1; phase_s<=0.
  - SpSVLD_HALF=hold. SpSBUS_HALF = phase_s ? buf_reg[2*HW-1:HW] : buf_reg[HW-1:0].
  - Half accept at phase 0: phase_s<=1.
  - Half accept at phase 1: hold<=0, unless a new full word is accepted the same cycle, in which case hold stays 1 and phase_s<=0.
  - Latency: beat 0 is valid the cycle after the full word is accepted. Back-to-back full words give a gapless half stream.
- The two paths are fully independent. A stall on one never affects the other.
- There are no error or overflow conditions; backpressure only.

Test Plan:
- Reset: hold RST=1 for 2 cycles with random inputs -> SpMVLD_FULL=0, SpSVLD_HALF=0, SpMRDY_HALF=1, SpSRDY_FULL=1 from the cycle after rst_in is seen.
- Expand basic (BWIDTH=64): send half beats 0x0_11223344, then 0x1_55667788 with SpMRDY_FULL=1 -> one cycle later SpMVLD_FULL=1, SpMBUS_FULL={0x1_55667788,0x0_11223344} (66 bits), valid for 1 cycle.
- Expand backpressure: SpMRDY_FULL=0, stream 4 half beats -> word A held stable; the 3rd beat is accepted; SpMRDY_HALF=0 on the 4th. Release ready -> word B follows with no data loss and no reordering.
- Reduce basic: SpSBUS_FULL=66'h2_AAAA_BBBB_CCCC_DDDD, SpSRDY_HALF=1 -> two consecutive half beats: low 33 bits, then high 33 bits; SpSRDY_FULL high again in the 2nd beat's cycle.
- Reduce streaming with random SpSRDY_HALF stalls, 100 words -> scoreboard matches the split order exactly; SpSBUS_HALF stays stable while stalled.
- Reset mid-operation: assert RST after one expand low beat and during reduce phase 1 -> after reset, the next half beat is treated as low; no stale beat or word is emitted.
